// File: rtl/game_life_pkg.sv
// Shared types for the Game of Life board datapath: board geometry,
// requester identities and the read-return tag carried alongside RAM commands.
package game_life_pkg;

  localparam int BOARD_ADDR_W = 12;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_DISP = 2'd1,
    REQ_ENG  = 2'd2,
    REQ_WR   = 2'd3
  } req_id_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_ENG  = 2'd2
  } ret_tag_t;

  typedef enum logic {
    RR_ENG = 1'b0,
    RR_WR  = 1'b1
  } rr_ptr_t;

  // Only reads produce a return; writes and idle slots travel as TAG_NONE.
  function automatic ret_tag_t tag_of(input req_id_t id);
    ret_tag_t tag;
    tag = TAG_NONE;
    case (id)
      REQ_DISP: tag = TAG_DISP;
      REQ_ENG:  tag = TAG_ENG;
      default:  tag = TAG_NONE;
    endcase
    return tag;
  endfunction

endpackage

// File: rtl/ret_tag_pipe.sv
// DEPTH-stage shift register for read-return tags with synchronous clear,
// used to line a tag up with data coming back from a fixed-latency memory.
module ret_tag_pipe
  import game_life_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  ret_tag_t tag_in,
  output ret_tag_t tag_out
);

  ret_tag_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= TAG_NONE;
      end
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/board_port_arbiter.sv
// Shares the single-port board RAM between display scan, update engine and writer:
// display first, engine/writer round-robin, registered command, tagged read returns.
module board_port_arbiter
  import game_life_pkg::*;
#(
  parameter int ADDR_W     = BOARD_ADDR_W,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rvalid,
  output logic              disp_rdata,
  input  logic              eng_req,
  input  logic [ADDR_W-1:0] eng_addr,
  output logic              eng_gnt,
  output logic              eng_rvalid,
  output logic              eng_rdata,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_data,
  output logic              wr_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wdata,
  input  logic              mem_rdata,
  output logic              starve_err
);

  localparam int               CNT_W      = 10;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT    = '1;

  req_id_t          winner;
  rr_ptr_t          rr_ptr;
  rr_ptr_t          rr_next;
  ret_tag_t         cmd_tag;
  ret_tag_t         ret_tag;
  logic [CNT_W-1:0] eng_wait;
  logic [CNT_W-1:0] eng_wait_next;
  logic [CNT_W-1:0] wr_wait;
  logic [CNT_W-1:0] wr_wait_next;

  // The display is never stalled; a lone engine/writer request ignores the pointer.
  always_comb begin
    winner  = REQ_NONE;
    rr_next = rr_ptr;
    if (disp_req) begin
      winner = REQ_DISP;
    end else if (eng_req && wr_req) begin
      winner = (rr_ptr == RR_ENG) ? REQ_ENG : REQ_WR;
    end else if (eng_req) begin
      winner = REQ_ENG;
    end else if (wr_req) begin
      winner = REQ_WR;
    end

    if (winner == REQ_ENG) begin
      rr_next = RR_WR;
    end else if (winner == REQ_WR) begin
      rr_next = RR_ENG;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= RR_ENG;
    end else begin
      rr_ptr <= rr_next;
    end
  end

  assign eng_gnt = rst_n && (winner == REQ_ENG);
  assign wr_gnt  = rst_n && (winner == REQ_WR);

  // Address and write data hold through idle slots so the RAM bus stays quiet.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 1'b0;
      cmd_tag   <= TAG_NONE;
    end else begin
      mem_en  <= (winner != REQ_NONE);
      mem_we  <= (winner == REQ_WR);
      cmd_tag <= tag_of(winner);
      case (winner)
        REQ_DISP: mem_addr <= disp_addr;
        REQ_ENG:  mem_addr <= eng_addr;
        REQ_WR: begin
          mem_addr  <= wr_addr;
          mem_wdata <= wr_data;
        end
        default: ;
      endcase
    end
  end

  // cmd_tag already spends one cycle with the command, the pipe adds the RAM latency.
  ret_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_ret_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (cmd_tag),
    .tag_out (ret_tag)
  );

  assign disp_rvalid = rst_n && (ret_tag == TAG_DISP);
  assign eng_rvalid  = rst_n && (ret_tag == TAG_ENG);
  assign disp_rdata  = mem_rdata;
  assign eng_rdata   = mem_rdata;

  always_comb begin
    eng_wait_next = eng_wait;
    wr_wait_next  = wr_wait;
    if (eng_gnt) begin
      eng_wait_next = '0;
    end else if (eng_req && (eng_wait != CNT_SAT)) begin
      eng_wait_next = eng_wait + 10'd1;
    end
    if (wr_gnt) begin
      wr_wait_next = '0;
    end else if (wr_req && (wr_wait != CNT_SAT)) begin
      wr_wait_next = wr_wait + 10'd1;
    end
  end

  // starve_err is sticky until reset so software can see a past overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      eng_wait   <= '0;
      wr_wait    <= '0;
      starve_err <= 1'b0;
    end else begin
      eng_wait <= eng_wait_next;
      wr_wait  <= wr_wait_next;
      if ((eng_wait_next >= STARVE_LIM) || (wr_wait_next >= STARVE_LIM)) begin
        starve_err <= 1'b1;
      end
    end
  end

endmodule
